// File: rtl/mul_pkg.sv
// mul_pkg: shared operand/product/tag types and default multiplier latency for mul_stream_ctrl
package mul_pkg;
    typedef logic [63:0]  operand_t;
    typedef logic [127:0] product_t;
    typedef logic [7:0]   tag_t;
    localparam int MUL_LATENCY = 6;
endpackage

// File: rtl/mul_out_fifo.sv
// mul_out_fifo: synchronous FIFO with registered count and empty flag; head reads as zero when empty
module mul_out_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [W-1:0]            din_i,
    input  logic                    pop_i,
    output logic [W-1:0]            dout_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, pop;
    assign pop     = pop_i && !empty_q;
    assign count_d = count_q + CW'(push_i) - CW'(pop);
    assign dout_o  = empty_q ? '0 : mem_q[rd_q];
    assign count_o = count_q;
    assign empty_o = empty_q;
    // pointers, occupancy and empty flag advance on push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end
    // storage array is not reset; empty gating hides stale contents
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/mul_stream_ctrl.sv
// mul_stream_ctrl: credit-based stream wrapper around a fixed-latency multiplier; MUL_TAG_EN adds an 8-bit tag path
import mul_pkg::*;
module mul_stream_ctrl #(
    parameter int LATENCY    = MUL_LATENCY,
    parameter int FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    output logic     in_ready,
    input  operand_t in_a,
    input  operand_t in_b,
`ifdef MUL_TAG_EN
    input  tag_t     in_tag,
    output tag_t     out_tag,
`endif
    output operand_t mul_a,
    output operand_t mul_b,
    output logic     mul_rst_n,
    input  product_t mul_out,
    output logic     out_valid,
    input  logic     out_ready,
    output product_t out_data,
    output logic     busy
);
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;
`ifdef MUL_TAG_EN
    localparam int W = 136;
`else
    localparam int W = 128;
`endif
    logic [LATENCY:0]          vpipe_q, vpipe_d;
    operand_t                  a_q, b_q;
    logic [CW-1:0]             inflight, credits;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      fifo_empty, accept;
    logic [W-1:0]              fifo_din, fifo_dout;
    assign accept    = in_valid && in_ready;
    assign vpipe_d   = {vpipe_q[LATENCY-1:0], accept};
    assign credits   = inflight + CW'(fifo_count);
    assign in_ready  = credits < CW'(FIFO_DEPTH);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_rst_n = ~rst;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout[127:0];
    assign busy      = (|vpipe_q) || !fifo_empty;
    // in-flight operation count from the valid shift register
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LATENCY; i++) inflight = inflight + CW'(vpipe_q[i]);
    end
    // operand registers load on accept; valid pipe shifts every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            vpipe_q <= vpipe_d;
            a_q     <= accept ? in_a : a_q;
            b_q     <= accept ? in_b : b_q;
        end
    end
`ifdef MUL_TAG_EN
    logic [LATENCY:0][7:0] tpipe_q;
    assign fifo_din = {tpipe_q[LATENCY], mul_out};
    assign out_tag  = fifo_dout[135:128];
    // tag travels alongside the valid bit so it reaches the FIFO with its product
    always_ff @(posedge clk) begin
        if (rst) tpipe_q <= '0;
        else tpipe_q <= {tpipe_q[LATENCY-1:0], in_tag};
    end
`else
    assign fifo_din = mul_out;
`endif
    mul_out_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (vpipe_q[LATENCY]),
        .din_i   (fifo_din),
        .pop_i   (out_ready),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_mul_stream_ctrl.sv
// tb_mul_stream_ctrl: randomized and directed bench for mul_stream_ctrl against a due-time queue model
module tb_mul_stream_ctrl;
    import mul_pkg::*;
    localparam int LAT   = 6;
    localparam int DEPTH = 8;

    logic     clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    operand_t in_a = '0, in_b = '0;
    tag_t     in_tag = '0;
    logic     in_ready, mul_rst_n, out_valid, busy;
    operand_t mul_a, mul_b;
    product_t mul_out, out_data;
`ifdef MUL_TAG_EN
    tag_t     out_tag;
`endif

    mul_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef MUL_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_rst_n (mul_rst_n),
        .mul_out   (mul_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // stand-in for the external pipelined multiplier: LAT register stages
    product_t stg [LAT];
    always @(posedge clk) begin
        stg[0] <= 128'(mul_a) * 128'(mul_b);
        for (int k = 1; k < LAT; k++) stg[k] <= stg[k-1];
    end
    assign mul_out = stg[LAT-1];

    int checks = 0, fails = 0;
    bit chk_en = 0;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // reference model: accepted items wait until their due edge, then sit in an ordered FIFO queue
    typedef struct { int due; product_t p; tag_t t; } item_t;
    item_t    pend[$], fq[$];
    int       ecnt = 0;
    operand_t la = '0, lb = '0;
    bit       m_acc;

    function automatic int credits();
        return pend.size() + fq.size();
    endfunction

    always @(posedge clk) begin
        ecnt++;
        if (rst) begin
            pend.delete();
            fq.delete();
            la = '0;
            lb = '0;
        end else begin
            m_acc = in_valid && (credits() < DEPTH);
            if (fq.size() > 0 && out_ready) void'(fq.pop_front());
            if (pend.size() > 0 && pend[0].due == ecnt) fq.push_back(pend.pop_front());
            if (m_acc) begin
                pend.push_back('{due: ecnt + LAT + 1, p: 128'(in_a) * 128'(in_b), t: in_tag});
                la = in_a;
                lb = in_b;
            end
        end
    end

    // every-cycle comparison against the model, plus collection of popped results
    product_t got[$];
    tag_t     gtag[$];
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, credits() < DEPTH);
            chk("out_valid", out_valid, fq.size() > 0);
            chk("out_data", out_data, fq.size() > 0 ? fq[0].p : '0);
            chk("busy", busy, credits() > 0);
            chk("mul_a", mul_a, la);
            chk("mul_b", mul_b, lb);
            chk("mul_rst_n", mul_rst_n, !rst);
`ifdef MUL_TAG_EN
            chk("out_tag", out_tag, fq.size() > 0 ? fq[0].t : '0);
`endif
        end
        if (out_valid && out_ready && !rst) begin
            got.push_back(out_data);
`ifdef MUL_TAG_EN
            gtag.push_back(out_tag);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input operand_t a, input operand_t b, input tag_t t);
        bit ok;
        ok = 0;
        in_valid = 1;
        in_a = a;
        in_b = b;
        in_tag = t;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && credits() > 0; k++) step();
        checks++;
        if (credits() > 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", credits());
        end
    endtask

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1);
    end

    int lat, nacc, sv;
    initial begin
        repeat (3) step();
        rst = 0;
        chk_en = 1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_a", mul_a, 0);

        // single max-value operation, latency and full-width product
        out_ready = 1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            if (out_valid) lat = k;
        end
        chk("t1_latency", lat, 7);
        chk("t1_product", out_data, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        drain();

        // back-to-back stream of 20 pairs
        got.delete();
        for (int i = 0; i < 20; i++) send(64'(i), 64'(i + 3), 8'h00);
        drain();
        chk("t2_count", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) chk("t2_result", got[i], 128'(i * (i + 3)));

        // full backpressure: credits cap the number of accepts
        got.delete();
        out_ready = 0;
        in_valid = 1;
        nacc = 0;
        for (int c = 0; c < 20; c++) begin
            in_a = 64'(100 + nacc);
            in_b = 64'd7;
            @(negedge clk);
            if (in_ready) nacc++;
            step();
        end
        in_valid = 0;
        chk("t3_accepts", nacc, 8);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_out_valid", out_valid, 1);
        out_ready = 1;
        drain();
        chk("t3_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("t3_result", got[i], 128'((100 + i) * 7));

        // randomized handshakes on both sides
        got.delete();
        nacc = 0;
        for (int c = 0; c < 2000; c++) begin
            in_valid = 1'($urandom % 2);
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            in_tag = 8'($urandom);
            out_ready = 1'($urandom % 2);
            @(negedge clk);
            if (in_valid && in_ready) nacc++;
            step();
        end
        in_valid = 0;
        out_ready = 1;
        drain();
        chk("t4_no_loss", got.size(), nacc);

        // reset with work in flight and entries held in the FIFO
        got.delete();
        out_ready = 0;
        send(64'd11, 64'd12, 8'h00);
        send(64'd13, 64'd14, 8'h00);
        repeat (8) step();
        send(64'd15, 64'd16, 8'h00);
        send(64'd17, 64'd18, 8'h00);
        send(64'd19, 64'd20, 8'h00);
        chk("t5_pre_out_valid", out_valid, 1);
        rst = 1;
        step();
        rst = 0;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_mul_a", mul_a, 0);
        out_ready = 1;
        sv = 0;
        repeat (10) begin
            step();
            if (out_valid) sv++;
        end
        chk("t5_stale", sv, 0);
        chk("t5_got", got.size(), 0);

`ifdef MUL_TAG_EN
        // tags ride with their products under random backpressure
        got.delete();
        gtag.delete();
        fork
            for (int i = 1; i <= 10; i++) send(64'(i * 11), 64'(i + 5), 8'(i));
            begin
                repeat (80) begin
                    out_ready = 1'($urandom % 2);
                    step();
                end
                out_ready = 1;
            end
        join
        drain();
        chk("t6_count", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            chk("t6_data", got[i], 128'((i + 1) * 11 * (i + 6)));
            chk("t6_tag", gtag[i], 128'(i + 1));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
